// File: rtl/pitch_stabilizer.sv
// pitch_stabilizer: tracks a DEPTH-bin window and emits its average once the spread is within TOL.
// Optional macro PITCH_STAB_HOLD_EN re-emits the last stable pitch on unstable windows.
module pitch_stabilizer #(
  parameter int W = 10,
  parameter int DEPTH = 4,
  parameter int TOL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] bin_data,
  input  logic         bin_valid,
  output logic         bin_ready,
  output logic [W-1:0] pitch_data,
  output logic         pitch_valid,
  input  logic         pitch_ready,
  output logic         locked
);
  localparam int LD = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = W + LD;
  typedef enum logic {FILL, TRACK} state_t;
  state_t state_q, state_d;
  logic [W-1:0] hist_q [DEPTH];
  logic [W-1:0] hist_d [DEPTH];
  logic [CW-1:0] fill_count_q, fill_count_d;
  logic eval_pending_q, eval_pending_d;
  logic [W-1:0] pitch_data_q, pitch_data_d;
  logic pitch_valid_q, pitch_valid_d;
  logic locked_q, locked_d;
  logic accept, zero, stable;
  logic [W-1:0] mx, mn, avg;
  logic [SW-1:0] sum;
`ifdef PITCH_STAB_HOLD_EN
  logic [W-1:0] last_stable_q, last_stable_d;
  logic has_stable_q, has_stable_d;
`endif
  assign bin_ready = !eval_pending_q && (!pitch_valid_q || pitch_ready);
  assign accept = bin_valid && bin_ready;
  assign zero = bin_data == '0;
  assign pitch_data = pitch_data_q;
  assign pitch_valid = pitch_valid_q;
  assign locked = locked_q;
  always_comb begin
    mx = hist_q[0];
    mn = hist_q[0];
    sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mx = hist_q[i] > mx ? hist_q[i] : mx;
      mn = hist_q[i] < mn ? hist_q[i] : mn;
      sum = sum + SW'(hist_q[i]);
    end
    avg = W'(sum >> LD);
    stable = (mx - mn) <= W'(TOL);
  end
  // an accepted bin and an evaluation never share an edge: bin_ready is low while eval_pending
  always_comb begin
    state_d = state_q;
    hist_d = hist_q;
    fill_count_d = fill_count_q;
    eval_pending_d = 1'b0;
    pitch_data_d = pitch_data_q;
    pitch_valid_d = pitch_valid_q && !pitch_ready;
    locked_d = locked_q;
`ifdef PITCH_STAB_HOLD_EN
    last_stable_d = last_stable_q;
    has_stable_d = has_stable_q;
`endif
    if (accept && zero) begin
      for (int i = 0; i < DEPTH; i++) hist_d[i] = '0;
      fill_count_d = '0;
      state_d = FILL;
      locked_d = 1'b0;
`ifdef PITCH_STAB_HOLD_EN
      last_stable_d = '0;
      has_stable_d = 1'b0;
`endif
    end else if (accept) begin
      hist_d[0] = bin_data;
      for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
      fill_count_d = fill_count_q == CW'(DEPTH) ? fill_count_q : fill_count_q + 1'b1;
      state_d = fill_count_d == CW'(DEPTH) ? TRACK : FILL;
      eval_pending_d = fill_count_d == CW'(DEPTH);
    end
    if (eval_pending_q) begin
      locked_d = stable;
      if (stable) begin
        pitch_data_d = avg;
        pitch_valid_d = 1'b1;
`ifdef PITCH_STAB_HOLD_EN
        last_stable_d = avg;
        has_stable_d = 1'b1;
`endif
      end
`ifdef PITCH_STAB_HOLD_EN
      else if (has_stable_q) begin
        pitch_data_d = last_stable_q;
        pitch_valid_d = 1'b1;
      end
`endif
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      fill_count_q <= '0;
      eval_pending_q <= 1'b0;
      pitch_data_q <= '0;
      pitch_valid_q <= 1'b0;
      locked_q <= 1'b0;
`ifdef PITCH_STAB_HOLD_EN
      last_stable_q <= '0;
      has_stable_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      hist_q <= hist_d;
      fill_count_q <= fill_count_d;
      eval_pending_q <= eval_pending_d;
      pitch_data_q <= pitch_data_d;
      pitch_valid_q <= pitch_valid_d;
      locked_q <= locked_d;
`ifdef PITCH_STAB_HOLD_EN
      last_stable_q <= last_stable_d;
      has_stable_q <= has_stable_d;
`endif
    end
  end
endmodule

// File: tb/tb_pitch_stabilizer.sv
// tb_pitch_stabilizer: scoreboard bench for pitch_stabilizer (default build, DEPTH=4, TOL=2, W=10).
module tb_pitch_stabilizer;
  logic clk = 0;
  logic reset = 1;
  logic [9:0] bin_data = '0;
  logic bin_valid = 0;
  logic bin_ready;
  logic [9:0] pitch_data;
  logic pitch_valid;
  logic pitch_ready = 1;
  logic locked;
  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;
  int got_cnt = 0;
  int sb[$];
  int win[4];
  int fill = 0;
  logic exp_locked = 0;

  pitch_stabilizer #(.W(10), .DEPTH(4), .TOL(2)) dut (
    .clk(clk), .reset(reset), .bin_data(bin_data), .bin_valid(bin_valid),
    .bin_ready(bin_ready), .pitch_data(pitch_data), .pitch_valid(pitch_valid),
    .pitch_ready(pitch_ready), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_clear();
    fill = 0;
    exp_locked = 0;
    for (int i = 0; i < 4; i++) win[i] = 0;
  endtask

  task automatic model_accept(input int b);
    int mx, mn, s;
    if (b == 0) begin
      model_clear();
      return;
    end
    for (int i = 3; i > 0; i--) win[i] = win[i-1];
    win[0] = b;
    if (fill < 4) fill++;
    if (fill == 4) begin
      mx = win[0]; mn = win[0]; s = 0;
      for (int i = 0; i < 4; i++) begin
        if (win[i] > mx) mx = win[i];
        if (win[i] < mn) mn = win[i];
        s += win[i];
      end
      exp_locked = (mx - mn) <= 2;
      if (exp_locked) begin
        sb.push_back(s / 4);
        exp_cnt++;
      end
    end
  endtask

  task automatic send(input int b);
    int n = 0;
    @(negedge clk);
    bin_data = 10'(b);
    bin_valid = 1;
    #1;
    while (!bin_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("accept_wait", n < 50, 1);
    @(posedge clk);
    model_accept(b);
    #1;
    bin_valid = 0;
  endtask

  task automatic settle(input string tag);
    repeat (5) @(negedge clk);
    #2;
    chk({tag, "_drained"}, sb.size(), 0);
    chk({tag, "_count"}, got_cnt, exp_cnt);
    chk({tag, "_locked"}, locked, exp_locked);
  endtask

  always @(negedge clk) begin
    #1;
    if (pitch_valid && pitch_ready) begin
      got_cnt++;
      if (sb.size() == 0) chk("extra_output", got_cnt, exp_cnt);
      else chk("pitch_data", pitch_data, sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_valid", pitch_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_ready", bin_ready, 1);
    chk("rst_data", pitch_data, 0);
    @(negedge clk);
    reset = 0;
    // stable window, checking output latency on the 4th bin
    send(100); send(100); send(100 + 1);
    chk("no_early_out", pitch_valid, 0);
    send(102);
    chk("lat_not_yet", pitch_valid, 0);
    chk("eval_stall", bin_ready, 0);
    @(posedge clk); #1;
    chk("lat_valid", pitch_valid, 1);
    chk("lat_data", pitch_data, 100);
    settle("s029");
    // unstable window
    send(0);
    send(100); send(100); send(100); send(110);
    settle("s030");
    // zero bin clears a locked window
    send(0);
    for (int i = 0; i < 4; i++) send(50);
    send(0);
    for (int i = 0; i < 3; i++) send(60);
    settle("s031");
    // backpressure
    send(0);
    for (int i = 0; i < 3; i++) send(70);
    pitch_ready = 0;
    send(70);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("bp_valid", pitch_valid, 1);
      chk("bp_data", pitch_data, 70);
      chk("bp_ready", bin_ready, 0);
    end
    @(negedge clk);
    pitch_ready = 1;
    @(posedge clk); #2;
    chk("bp_released", pitch_valid, 0);
    settle("s032");
    // asynchronous reset, first from a locked state then mid-window
    @(negedge clk); #3;
    chk("pre_rst_locked", locked, 1);
    reset = 1;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_data", pitch_data, 0);
    chk("arst_ready", bin_ready, 1);
    model_clear();
    @(negedge clk); reset = 0;
    send(5); send(5);
    #2; reset = 1; #1;
    chk("arst2_valid", pitch_valid, 0);
    chk("arst2_ready", bin_ready, 1);
    model_clear();
    @(negedge clk); reset = 0;
    send(5); send(5); send(5);
    settle("s033a");
    send(5);
    settle("s033b");
    // full-scale bins and TOL boundary
    send(0);
    for (int i = 0; i < 4; i++) send(1023);
    send(1021);
    settle("s034");
    send(0);
    send(200); send(201); send(202); send(203);
    settle("tol_plus1");
    send(201);
    settle("tol_edge");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
